// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache:
// trace command codes, controller state encoding and a clog2 helper.
package icache_pkg;

   localparam logic [3:0] CMD_INST_FETCH = 4'd2;
   localparam logic [3:0] CMD_INVALIDATE = 4'd3;
   localparam logic [3:0] CMD_RESET      = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_FILL, S_CLEAR, S_RESP
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/icache_lru.sv
// True-LRU helper for one set: ages form a permutation with 0 = MRU.
// Produces the ages after touching one way and the replacement victim.
module icache_lru
   import icache_pkg::*;
#(
   parameter int WAYS = 4,
   parameter int AW   = clog2(WAYS)
) (
   input  logic [WAYS-1:0][AW-1:0] age_i,
   input  logic [WAYS-1:0]         valid_i,
   input  logic [AW-1:0]           touch_i,
   output logic [WAYS-1:0][AW-1:0] age_o,
   output logic [AW-1:0]           victim_o
);

   always_comb begin
      age_o = age_i;
      for (int w = 0; w < WAYS; w++)
         if (age_i[w] < age_i[touch_i]) age_o[w] = age_i[w] + 1'b1;
      age_o[touch_i] = '0;
   end

   // An invalid way always beats the oldest one; descending scan leaves the lowest.
   always_comb begin
      victim_o = '0;
      for (int w = 0; w < WAYS; w++)
         if (age_i[w] == AW'(WAYS - 1)) victim_o = AW'(w);
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid_i[w]) victim_o = AW'(w);
   end

endmodule

// File: rtl/icache_assoc.sv
// Blocking N-way set-associative I-cache with true-LRU and a handshaked line refill.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache_assoc
   import icache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int SETS       = 64,
   parameter int WAYS       = 4,
   parameter int LINE_BYTES = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [3:0]              req_cmd,
   input  logic [ADDR_W-1:0]       req_addr,
   output logic                    rsp_valid,
   output logic                    rsp_hit,
   output logic                    rsp_miss,
   output logic [31:0]             rsp_data,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [ADDR_W-1:0]       mem_addr,
   input  logic                    mem_rsp_valid,
   input  logic [8*LINE_BYTES-1:0] mem_rsp_data
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]             hit_count,
   output logic [31:0]             miss_count
`endif
);

   localparam int OFF_W  = clog2(LINE_BYTES);
   localparam int IDX_W  = clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int LINE_W = 8 * LINE_BYTES;
   localparam int AW     = clog2(WAYS);

   state_t                          state_q, state_d;
   logic [3:0]                      cmd_q, cmd_d;
   logic [ADDR_W-1:0]               addr_q, addr_d, mem_addr_q, mem_addr_d;
   logic                            req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
   logic                            rsp_hit_q, rsp_hit_d, rsp_miss_q, rsp_miss_d;
   logic [31:0]                     rsp_data_q, rsp_data_d, res_data_q, res_data_d;
   logic                            res_hit_q, res_hit_d, res_miss_q, res_miss_d;
   logic                            mem_req_valid_q, mem_req_valid_d;
   logic [IDX_W-1:0]                clr_idx_q, clr_idx_d;
   logic [SETS-1:0][WAYS-1:0]       valid_q, valid_d;
   logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q, tag_d;
   logic [SETS-1:0][WAYS-1:0][AW-1:0]    age_q, age_d;
   logic [LINE_W-1:0]               data_q [SETS][WAYS];
   logic [LINE_W-1:0]               line_q;
   logic                            line_we, fill_we;

   logic [TAG_W-1:0]                tag_a;
   logic [IDX_W-1:0]                idx_a;
   logic [OFF_W-3:0]                wsel;
   logic [WAYS-1:0]                 match;
   logic [AW-1:0]                   hit_way, victim, touch;
   logic [WAYS-1:0][AW-1:0]         age_nxt;
   logic [31:0]                     hit_word, fill_word;
   logic                            lsb_unused;

   assign tag_a      = addr_q[ADDR_W-1:IDX_W+OFF_W];
   assign idx_a      = addr_q[IDX_W+OFF_W-1:OFF_W];
   assign wsel       = addr_q[OFF_W-1:2];
   assign lsb_unused = ^addr_q[1:0];

   always_comb begin
      match   = '0;
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         match[w] = valid_q[idx_a][w] && (tag_q[idx_a][w] == tag_a);
         if (match[w]) hit_way = AW'(w);
      end
   end

   assign touch     = (state_q == S_FILL) ? victim : hit_way;
   assign hit_word  = data_q[idx_a][hit_way][32*int'(wsel) +: 32];
   assign fill_word = line_q[32*int'(wsel) +: 32];

   icache_lru #(.WAYS(WAYS), .AW(AW)) u_lru (
      .age_i   (age_q[idx_a]),
      .valid_i (valid_q[idx_a]),
      .touch_i (touch),
      .age_o   (age_nxt),
      .victim_o(victim)
   );

   always_comb begin
      state_d         = state_q;
      cmd_d           = cmd_q;
      addr_d          = addr_q;
      rsp_valid_d     = 1'b0;
      rsp_hit_d       = rsp_hit_q;
      rsp_miss_d      = rsp_miss_q;
      rsp_data_d      = rsp_data_q;
      res_hit_d       = res_hit_q;
      res_miss_d      = res_miss_q;
      res_data_d      = res_data_q;
      mem_req_valid_d = mem_req_valid_q;
      mem_addr_d      = mem_addr_q;
      clr_idx_d       = clr_idx_q;
      valid_d         = valid_q;
      tag_d           = tag_q;
      age_d           = age_q;
      line_we         = 1'b0;
      fill_we         = 1'b0;
      case (state_q)
         S_IDLE: if (req_valid && req_ready_q) begin
            cmd_d     = req_cmd;
            addr_d    = req_addr;
            clr_idx_d = '0;
            state_d   = (req_cmd == CMD_RESET) ? S_CLEAR : S_LOOKUP;
         end
         S_LOOKUP: begin
            res_hit_d  = 1'b0;
            res_miss_d = 1'b0;
            state_d    = S_RESP;
            if (cmd_q == CMD_INST_FETCH) begin
               if (|match) begin
                  age_d[idx_a] = age_nxt;
                  res_hit_d    = 1'b1;
                  res_data_d   = hit_word;
               end else begin
                  mem_addr_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  state_d    = S_MISS_REQ;
               end
            end else if (cmd_q == CMD_INVALIDATE) begin
               valid_d[idx_a] = valid_q[idx_a] & ~match;
            end
         end
         // Request is raised one cycle into MISS_REQ so it always comes from a flop.
         S_MISS_REQ: begin
            if (!mem_req_valid_q) mem_req_valid_d = 1'b1;
            else if (mem_req_ready) begin
               mem_req_valid_d = 1'b0;
               state_d         = S_MISS_WAIT;
            end
         end
         S_MISS_WAIT: if (mem_rsp_valid) begin
            line_we = 1'b1;
            state_d = S_FILL;
         end
         S_FILL: begin
            fill_we                = 1'b1;
            valid_d[idx_a][victim] = 1'b1;
            tag_d[idx_a][victim]   = tag_a;
            age_d[idx_a]           = age_nxt;
            res_hit_d              = 1'b0;
            res_miss_d             = 1'b1;
            res_data_d             = fill_word;
            state_d                = S_RESP;
         end
         S_CLEAR: begin
            valid_d[clr_idx_q] = '0;
            for (int w = 0; w < WAYS; w++) age_d[clr_idx_q][w] = AW'(w);
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(SETS - 1)) begin
               res_hit_d  = 1'b0;
               res_miss_d = 1'b0;
               state_d    = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid_d = 1'b1;
            rsp_hit_d   = res_hit_q;
            rsp_miss_d  = res_miss_q;
            rsp_data_d  = res_data_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      req_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         cmd_q           <= '0;
         addr_q          <= '0;
         req_ready_q     <= 1'b0;
         rsp_valid_q     <= 1'b0;
         rsp_hit_q       <= 1'b0;
         rsp_miss_q      <= 1'b0;
         rsp_data_q      <= '0;
         res_hit_q       <= 1'b0;
         res_miss_q      <= 1'b0;
         res_data_q      <= '0;
         mem_req_valid_q <= 1'b0;
         mem_addr_q      <= '0;
         clr_idx_q       <= '0;
         valid_q         <= '0;
         tag_q           <= '0;
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      end else begin
         state_q         <= state_d;
         cmd_q           <= cmd_d;
         addr_q          <= addr_d;
         req_ready_q     <= req_ready_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_hit_q       <= rsp_hit_d;
         rsp_miss_q      <= rsp_miss_d;
         rsp_data_q      <= rsp_data_d;
         res_hit_q       <= res_hit_d;
         res_miss_q      <= res_miss_d;
         res_data_q      <= res_data_d;
         mem_req_valid_q <= mem_req_valid_d;
         mem_addr_q      <= mem_addr_d;
         clr_idx_q       <= clr_idx_d;
         valid_q         <= valid_d;
         tag_q           <= tag_d;
         age_q           <= age_d;
      end
   end

   // Line storage carries no reset; valid bits alone decide what is resident.
   always_ff @(posedge clk) begin
      if (line_we) line_q <= mem_rsp_data;
      if (fill_we) data_q[idx_a][victim] <= line_q;
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_hit       = rsp_hit_q;
   assign rsp_miss      = rsp_miss_q;
   assign rsp_data      = rsp_data_q;
   assign mem_req_valid = mem_req_valid_q;
   assign mem_addr      = mem_addr_q;

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (rsp_valid_q && rsp_hit_q && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + 1'b1;
      if (rsp_valid_q && rsp_miss_q && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 1'b1;
      if (state_q == S_RESP && cmd_q == CMD_RESET) begin
         hit_cnt_d  = '0;
         miss_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: vector table plus multi-cycle sequences, scoreboarded responses.
module tb_icache_assoc;
   import icache_pkg::*;

   logic         clk, rst, req_valid, req_ready, rsp_valid, rsp_hit, rsp_miss;
   logic [3:0]   req_cmd;
   logic [31:0]  req_addr, rsp_data, mem_addr;
   logic         mem_req_valid, mem_req_ready, mem_rsp_valid;
   logic [127:0] mem_rsp_data;
`ifdef ICACHE_STATS_EN
   logic [31:0]  hit_count, miss_count;
   int           exp_hc = 0, exp_mc = 0;
`endif

   icache_assoc #(.ADDR_W(32), .SETS(4), .WAYS(4), .LINE_BYTES(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_addr(req_addr), .rsp_valid(rsp_valid),
      .rsp_hit(rsp_hit), .rsp_miss(rsp_miss), .rsp_data(rsp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef ICACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   typedef struct { logic [3:0] cmd; logic [31:0] addr; logic hit; logic miss; logic mem; } vec_t;
   typedef struct { logic hit; logic miss; logic [31:0] data; logic chk; } exp_t;

   exp_t sbq[$];
   vec_t tbl[20];
   int   n_vec = 0, n_err = 0, n_rsp = 0, n_memreq = 0;
   int   cyc = 0, acc_cyc = 0, fill_cyc = 0, last_rsp_cyc = 0;
   logic mreq_prev = 1'b0;

   initial begin clk = 1'b0; forever #5 clk = ~clk; end
   initial forever begin @(posedge clk); cyc++; end
   initial begin #200000; $display("FAIL watchdog: got timeout, want finish"); $fatal(1); end

   function automatic logic [31:0] mk_word(input logic [31:0] a);
      if (a == 32'h0000_1004) return 32'hDEADBEEF;
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   function automatic logic [127:0] mk_line(input logic [31:0] la);
      logic [127:0] l;
      for (int k = 0; k < 4; k++) l[32*k +: 32] = mk_word(la + 32'(4*k));
      return l;
   endfunction

   function automatic vec_t mkv(input logic [3:0] c, input logic [31:0] a,
                                input logic h, input logic m, input logic mem);
      vec_t v;
      v.cmd = c; v.addr = a; v.hit = h; v.miss = m; v.mem = mem;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp_v);
      end
   endtask

   // Response monitor and scoreboard
   initial begin : mon
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_req_valid && !mreq_prev) n_memreq++;
         mreq_prev = mem_req_valid;
         if (rsp_valid) begin
            n_rsp++;
            last_rsp_cyc = cyc;
            if (sbq.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_rsp: got hit=%b miss=%b, want no response", rsp_hit, rsp_miss);
            end else begin
               e = sbq.pop_front();
               chk("rsp_hitmiss", {30'b0, rsp_hit, rsp_miss}, {30'b0, e.hit, e.miss});
               if (e.chk) chk("rsp_data", rsp_data, e.data);
`ifdef ICACHE_STATS_EN
               if (e.hit) exp_hc++;
               if (e.miss) exp_mc++;
`endif
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [3:0] c, input logic [31:0] a);
      int k = 0;
      while (!req_ready && k < 50) begin step(); k++; end
      chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_cmd = c; req_addr = a;
      step();
      acc_cyc = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_mreq();
      int k = 0;
      while (!mem_req_valid && k < 50) begin step(); k++; end
      chk("mreq_seen", {31'b0, mem_req_valid}, 32'd1);
   endtask

   task automatic serve_mem(input logic [31:0] la, input int hold);
      wait_mreq();
      chk("mreq_lat", cyc - acc_cyc, 32'd2);
      chk("mem_addr", mem_addr, la);
      for (int h = 0; h < hold; h++) begin
         mem_rsp_valid = (h % 2 == 0);
         mem_rsp_data  = ~mk_line(la);
         step();
         chk("mem_addr_stable", mem_addr, la);
         chk("mreq_held", {31'b0, mem_req_valid}, 32'd1);
      end
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      chk("mreq_drop", {31'b0, mem_req_valid}, 32'd0);
      step();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mk_line(la);
      step();
      fill_cyc = cyc;
      mem_rsp_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int nr0);
      int k = 0;
      while (n_rsp == nr0 && k < 100) begin step(); k++; end
      chk("rsp_seen", n_rsp - nr0, 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int hold);
      int nr0, nm0;
      exp_t e;
      nr0 = n_rsp; nm0 = n_memreq;
      e.hit = v.hit; e.miss = v.miss; e.data = mk_word({v.addr[31:2], 2'b00});
      e.chk = (v.cmd == CMD_INST_FETCH);
      sbq.push_back(e);
      issue(v.cmd, v.addr);
      if (v.mem) serve_mem({v.addr[31:4], 4'h0}, hold);
      wait_rsp(nr0);
      if (v.mem) chk("fill_lat", last_rsp_cyc - fill_cyc, 32'd2);
      else begin
         chk("rsp_lat", last_rsp_cyc - acc_cyc, 32'd2);
         chk("no_memreq", n_memreq - nm0, 32'd0);
      end
   endtask

   initial begin : main
      int nr0, lo;
      exp_t e;
      req_valid = 1'b0; req_cmd = '0; req_addr = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #12;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_rsp_flags", {29'b0, rsp_valid, rsp_hit, rsp_miss}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_mreq", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      step();
      chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

      // Set 0 holds tags of 0x1000..0x7000; 0x1010/0x1014 sit in set 1.
      tbl[0]  = mkv(CMD_INST_FETCH, 32'h1004, 0, 1, 1);
      tbl[1]  = mkv(CMD_INST_FETCH, 32'h1004, 1, 0, 0);
      tbl[2]  = mkv(CMD_INST_FETCH, 32'h1008, 1, 0, 0);
      tbl[3]  = mkv(CMD_INST_FETCH, 32'h2000, 0, 1, 1);
      tbl[4]  = mkv(CMD_INST_FETCH, 32'h3000, 0, 1, 1);
      tbl[5]  = mkv(CMD_INST_FETCH, 32'h4000, 0, 1, 1);
      tbl[6]  = mkv(CMD_INST_FETCH, 32'h100C, 1, 0, 0);
      tbl[7]  = mkv(CMD_INST_FETCH, 32'h5000, 0, 1, 1);
      tbl[8]  = mkv(CMD_INST_FETCH, 32'h1000, 1, 0, 0);
      tbl[9]  = mkv(CMD_INST_FETCH, 32'h3004, 1, 0, 0);
      tbl[10] = mkv(CMD_INST_FETCH, 32'h4008, 1, 0, 0);
      tbl[11] = mkv(CMD_INST_FETCH, 32'h500C, 1, 0, 0);
      tbl[12] = mkv(CMD_INST_FETCH, 32'h2000, 0, 1, 1);
      tbl[13] = mkv(CMD_INST_FETCH, 32'h1010, 0, 1, 1);
      tbl[14] = mkv(CMD_INVALIDATE, 32'h3000, 0, 0, 0);
      tbl[15] = mkv(CMD_INST_FETCH, 32'h3004, 0, 1, 1);
      tbl[16] = mkv(CMD_INVALIDATE, 32'h7000, 0, 0, 0);
      tbl[17] = mkv(4'd5,           32'h4000, 0, 0, 0);
      tbl[18] = mkv(CMD_INST_FETCH, 32'h4000, 1, 0, 0);
      tbl[19] = mkv(CMD_INST_FETCH, 32'h1014, 1, 0, 0);
      for (int i = 0; i < 20; i++) run_vec(tbl[i], 0);
      chk("rsp_data_hold", rsp_data, mk_word(32'h1014));
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, exp_hc);
      chk("miss_count", miss_count, exp_mc);
`endif

      // Refill stalled by ready=0 with spurious line pulses in between.
      run_vec(mkv(CMD_INST_FETCH, 32'h6004, 0, 1, 1), 5);
      run_vec(mkv(CMD_INST_FETCH, 32'h6008, 1, 0, 0), 0);

      // RESET command: busy for SETS+1 cycles, then everything misses.
      nr0 = n_rsp;
      e.hit = 1'b0; e.miss = 1'b0; e.data = '0; e.chk = 1'b0;
      sbq.push_back(e);
      issue(CMD_RESET, 32'h0);
      lo = 0;
      while (!req_ready && lo < 50) begin lo++; step(); end
      chk("reset_busy_cycles", lo, 32'd5);
      wait_rsp(nr0);
`ifdef ICACHE_STATS_EN
      chk("hit_count_clr", hit_count, 32'd0);
      chk("miss_count_clr", miss_count, 32'd0);
      exp_hc = 0; exp_mc = 0;
`endif
      run_vec(mkv(CMD_INST_FETCH, 32'h1014, 0, 1, 1), 0);
      run_vec(mkv(CMD_INST_FETCH, 32'h6004, 0, 1, 1), 0);

      // rst while waiting for the line; a late line must not complete anything.
      nr0 = n_rsp;
      issue(CMD_INST_FETCH, 32'h8000);
      wait_mreq();
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      @(posedge clk); #3 rst = 1'b1;
      #1;
      chk("rst_wait_mreq", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_wait_ready", {31'b0, req_ready}, 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("rst_wait_idle", {31'b0, req_ready}, 32'd1);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mk_line(32'h8000);
      step();
      mem_rsp_valid = 1'b0;
      repeat (6) step();
      chk("stray_no_rsp", n_rsp - nr0, 32'd0);
      chk("stray_ready", {31'b0, req_ready}, 32'd1);
`ifdef ICACHE_STATS_EN
      chk("rst_hit_count", hit_count, 32'd0);
      exp_hc = 0; exp_mc = 0;
`endif

      // rst while the request is still being offered drops it without a clock edge.
      issue(CMD_INST_FETCH, 32'h9000);
      wait_mreq();
      #3 rst = 1'b1;
      #1;
      chk("rst_async_mreq", {31'b0, mem_req_valid}, 32'd0);
      step();
      rst = 1'b0;
      step();
      run_vec(mkv(CMD_INST_FETCH, 32'h8000, 0, 1, 1), 0);
      run_vec(mkv(CMD_INST_FETCH, 32'h8004, 1, 0, 0), 0);

      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
